// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one byte-enabled data memory between the CPU M stage
// (port 0) and a DMA/debug master (port 1). CPU has priority, but a waiting
// DMA request is forced through after WAIT_LIMIT contested cycles. Once the
// DMA master holds the memory it keeps it for up to MAX_BURST grants while
// the CPU is also asking. CPU sub-word stores get lane steering, and CPU
// loads get lane extraction with sign or zero extension.
module dm_arbiter #(
    parameter int MAX_BURST  = 4,
    parameter int WAIT_LIMIT = 8,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_op,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {S_CPU = 1'b0, S_DMA = 1'b1} state_t;

    localparam logic [CNT_W-1:0] L_MAX_BURST = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] L_WAIT_LIM  = CNT_W'(WAIT_LIMIT);

    state_t             r_state;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [31:0]        r_dma_rdata;
    logic               r_dma_rvalid;

    logic               w_cpu_gnt;
    logic               w_dma_gnt;
    logic               w_is_half;
    logic               w_is_byte;
    logic               w_is_word;
    logic               w_signed;
    logic               w_mis;
    logic [3:0]         w_cpu_be;
    logic [31:0]        w_cpu_wd;
    logic [31:0]        w_ld_sh;
    logic [31:0]        w_ld_data;

    // Decode the CPU access size; codes 5-7 fall through to word
    always_comb begin
        w_is_half = (cpu_op == 3'd1) || (cpu_op == 3'd2);
        w_is_byte = (cpu_op == 3'd3) || (cpu_op == 3'd4);
        w_is_word = !w_is_half && !w_is_byte;
        w_signed  = (cpu_op == 3'd1) || (cpu_op == 3'd3);
        w_mis     = (w_is_half && cpu_addr[0]) || (w_is_word && (cpu_addr[1:0] != 2'b00));
    end

    // Pick at most one requester per cycle from the current state and counters
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (r_state == S_CPU) begin
            if (cpu_req && (!dma_req || (r_wait_cnt < L_WAIT_LIM)))
                w_cpu_gnt = 1'b1;
            else if (dma_req)
                w_dma_gnt = 1'b1;
        end else begin
            if (dma_req && (!cpu_req || (r_burst_cnt < L_MAX_BURST)))
                w_dma_gnt = 1'b1;
            else if (cpu_req)
                w_cpu_gnt = 1'b1;
        end
    end

    // Steer CPU store data and byte enables onto the addressed lanes
    always_comb begin
        w_cpu_be = 4'hF;
        w_cpu_wd = cpu_wdata;
        if (w_is_half) begin
            w_cpu_be = 4'b0011 << cpu_addr[1:0];
            w_cpu_wd = {2{cpu_wdata[15:0]}};
        end else if (w_is_byte) begin
            w_cpu_be = 4'b0001 << cpu_addr[1:0];
            w_cpu_wd = {4{cpu_wdata[7:0]}};
        end
    end

    // Pull the addressed byte/half down to bit 0 and extend it
    always_comb begin
        w_ld_sh   = mem_rdata >> {cpu_addr[1:0], 3'b000};
        w_ld_data = mem_rdata;
        if (w_is_half)
            w_ld_data = w_signed ? {{16{w_ld_sh[15]}}, w_ld_sh[15:0]} : {16'h0, w_ld_sh[15:0]};
        else if (w_is_byte)
            w_ld_data = w_signed ? {{24{w_ld_sh[7]}}, w_ld_sh[7:0]} : {24'h0, w_ld_sh[7:0]};
    end

    // Memory port mux; a misaligned CPU grant leaves the memory untouched
    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_byteen = 4'h0;
        mem_wdata  = 32'h0;
        if (w_dma_gnt) begin
            mem_we     = dma_we;
            mem_addr   = dma_addr & 32'hFFFF_FFFC;
            mem_byteen = 4'hF;
            mem_wdata  = dma_wdata;
        end else if (w_cpu_gnt && !w_mis) begin
            mem_we     = cpu_we;
            mem_addr   = cpu_addr & 32'hFFFF_FFFC;
            mem_byteen = w_cpu_be;
            mem_wdata  = w_cpu_wd;
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign dma_gnt    = w_dma_gnt;
    assign cpu_stall  = cpu_req & ~w_cpu_gnt;
    assign cpu_err    = w_cpu_gnt & w_mis;
    assign cpu_rdata  = w_mis ? 32'h0 : w_ld_data;
    assign dma_rdata  = r_dma_rdata;
    assign dma_rvalid = r_dma_rvalid;

    // Arbitration FSM with saturating burst/wait counters and the DMA read register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_CPU;
            r_burst_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_dma_rdata  <= 32'h0;
            r_dma_rvalid <= 1'b0;
        end else begin
            r_dma_rvalid <= w_dma_gnt & ~dma_we;
            if (w_dma_gnt && !dma_we)
                r_dma_rdata <= mem_rdata;
            case (r_state)
                S_CPU: begin
                    if (w_cpu_gnt) begin
                        if (dma_req && (r_wait_cnt < L_WAIT_LIM))
                            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end else if (w_dma_gnt) begin
                        r_wait_cnt  <= '0;
                        r_burst_cnt <= CNT_W'(1);
                        r_state     <= S_DMA;
                    end else begin
                        r_wait_cnt <= '0;
                    end
                end
                S_DMA: begin
                    if (w_dma_gnt) begin
                        if (r_burst_cnt < L_MAX_BURST)
                            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                    end else begin
                        // either the burst ended or the CPU took its turn
                        r_burst_cnt <= '0;
                        r_state     <= S_CPU;
                    end
                end
                default: r_state <= S_CPU;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small byte-enabled memory model.
module tb_dm_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  cpu_op;
    logic        cpu_gnt, cpu_stall, cpu_err;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byteen;

    logic [31:0] mem [16];

    int ncmp = 0;
    int nerr = 0;

    dm_arbiter #(.MAX_BURST(4), .WAIT_LIMIT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_op(cpu_op),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: combinational read, clocked byte-enabled write
    assign mem_rdata = (mem_addr[31:6] == 26'h0 && mem_addr[1:0] == 2'b00) ?
                       mem[mem_addr[5:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteen[b]) mem[mem_addr[5:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu(input logic req, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] op);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_op = op;
    endtask

    task automatic dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4] = 32'h1234_5678;
        rst = 1'b0;
        cpu(0, 0, 0, 0, 0);
        dma(0, 0, 0, 0);

        // 1. reset and idle
        nxt(); nxt();
        @(negedge clk);
        chk("rst_rvalid", dma_rvalid, 0);
        chk("rst_rdata", dma_rdata, 0);
        rst = 1'b1;
        nxt();
        @(negedge clk);
        chk("idle_cgnt", cpu_gnt, 0);
        chk("idle_dgnt", dma_gnt, 0);
        chk("idle_stall", cpu_stall, 0);
        chk("idle_err", cpu_err, 0);
        chk("idle_we", mem_we, 0);
        chk("idle_be", mem_byteen, 0);
        chk("idle_addr", mem_addr, 0);
        chk("idle_wd", mem_wdata, 0);
        nxt();
        cpu(1, 0, 32'h10, 0, 3'd0);
        @(negedge clk);
        chk("rb_w4", cpu_rdata, 32'h1234_5678);
        nxt();
        cpu(1, 0, 32'h4, 0, 3'd0);
        @(negedge clk);
        chk("rb_w1", cpu_rdata, 32'h0);
        nxt();

        // 2. sub-word store and load
        cpu(1, 1, 32'h5, 32'h0000_00AB, 3'd3);
        @(negedge clk);
        chk("sb_gnt", cpu_gnt, 1);
        chk("sb_we", mem_we, 1);
        chk("sb_be", mem_byteen, 4'b0010);
        chk("sb_wd", mem_wdata, 32'hABAB_ABAB);
        chk("sb_addr", mem_addr, 32'h4);
        nxt();
        cpu(1, 0, 32'h5, 0, 3'd3);
        @(negedge clk);
        chk("lb", cpu_rdata, 32'hFFFF_FFAB);
        nxt();
        cpu(1, 0, 32'h5, 0, 3'd4);
        @(negedge clk);
        chk("lbu", cpu_rdata, 32'h0000_00AB);
        nxt();
        cpu(1, 1, 32'h6, 32'h5555_1234, 3'd1);
        @(negedge clk);
        chk("sh_be", mem_byteen, 4'b1100);
        chk("sh_wd", mem_wdata, 32'h1234_1234);
        nxt();
        cpu(1, 0, 32'h6, 0, 3'd1);
        @(negedge clk);
        chk("lh_hi", cpu_rdata, 32'h0000_1234);
        nxt();
        cpu(1, 0, 32'h4, 0, 3'd1);
        @(negedge clk);
        chk("lh_lo", cpu_rdata, 32'hFFFF_AB00);
        nxt();
        cpu(1, 0, 32'h4, 0, 3'd2);
        @(negedge clk);
        chk("lhu_lo", cpu_rdata, 32'h0000_AB00);
        nxt();

        // 3. misaligned accesses
        cpu(1, 0, 32'h6, 0, 3'd0);
        @(negedge clk);
        chk("mis_lw_err", cpu_err, 1);
        chk("mis_lw_gnt", cpu_gnt, 1);
        chk("mis_lw_stall", cpu_stall, 0);
        chk("mis_lw_we", mem_we, 0);
        chk("mis_lw_rd", cpu_rdata, 0);
        nxt();
        cpu(1, 1, 32'h3, 32'hFFFF_FFFF, 3'd1);
        @(negedge clk);
        chk("mis_sh_err", cpu_err, 1);
        chk("mis_sh_we", mem_we, 0);
        chk("mis_sh_be", mem_byteen, 0);
        nxt();
        cpu(1, 0, 32'h4, 0, 3'd0);
        @(negedge clk);
        chk("mis_nofx", cpu_rdata, 32'h1234_AB00);
        nxt();

        // 4a. DMA alone for 6 cycles, low address bits ignored
        cpu(0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            dma(1, 0, 32'h13, 0);
            @(negedge clk);
            chk("dma6_gnt", dma_gnt, 1);
            chk("dma6_cgnt", cpu_gnt, 0);
            chk("dma6_addr", mem_addr, 32'h10);
            chk("dma6_be", mem_byteen, 4'hF);
            nxt();
        end
        dma(0, 0, 0, 0);
        @(negedge clk);
        chk("dma6_rv", dma_rvalid, 1);
        nxt();

        // 4b. CPU joins in the third cycle of a burst
        for (int k = 0; k < 5; k++) begin
            dma(1, 0, 32'h10, 0);
            cpu(k >= 2, 0, 32'h4, 0, 3'd0);
            @(negedge clk);
            chk("burst_dgnt", dma_gnt, k < 4);
            chk("burst_cgnt", cpu_gnt, k == 4);
            chk("burst_stall", cpu_stall, (k == 2) || (k == 3));
            chk("burst_onehot", cpu_gnt & dma_gnt, 0);
            if (k == 4) chk("burst_rd", cpu_rdata, 32'h1234_AB00);
            nxt();
        end
        cpu(0, 0, 0, 0, 0);
        dma(0, 0, 0, 0);
        nxt();

        // 5. starvation guard: 8 CPU, 4 DMA, then CPU
        for (int k = 0; k < 13; k++) begin
            cpu(1, 0, 32'h4, 0, 3'd0);
            dma(1, 0, 32'h10, 0);
            @(negedge clk);
            chk("starve_cgnt", cpu_gnt, (k < 8) || (k == 12));
            chk("starve_dgnt", dma_gnt, (k >= 8) && (k < 12));
            chk("starve_stall", cpu_stall, (k >= 8) && (k < 12));
            nxt();
        end
        cpu(0, 0, 0, 0, 0);
        dma(0, 0, 0, 0);
        nxt();

        // DMA write, then CPU reads it back
        dma(1, 1, 32'h8, 32'hCAFE_BABE);
        @(negedge clk);
        chk("dw_we", mem_we, 1);
        chk("dw_wd", mem_wdata, 32'hCAFE_BABE);
        chk("dw_addr", mem_addr, 32'h8);
        nxt();
        dma(0, 0, 0, 0);
        cpu(1, 0, 32'h8, 0, 3'd0);
        @(negedge clk);
        chk("dw_rd", cpu_rdata, 32'hCAFE_BABE);
        chk("dw_norv", dma_rvalid, 0);
        nxt();
        cpu(0, 0, 0, 0, 0);

        // 6. DMA read latency and reset clearing rvalid
        dma(1, 0, 32'h10, 0);
        @(negedge clk);
        chk("dr_gnt", dma_gnt, 1);
        chk("dr_rv0", dma_rvalid, 0);
        nxt();
        dma(0, 0, 0, 0);
        @(negedge clk);
        chk("dr_rv1", dma_rvalid, 1);
        chk("dr_data", dma_rdata, 32'h1234_5678);
        nxt();
        @(negedge clk);
        chk("dr_rv2", dma_rvalid, 0);
        chk("dr_hold", dma_rdata, 32'h1234_5678);
        nxt();
        dma(1, 0, 32'h10, 0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("dr_rv_pre", dma_rvalid, 1);
        nxt();
        rst = 1'b1;
        dma(0, 0, 0, 0);
        @(negedge clk);
        chk("dr_rst_rv", dma_rvalid, 0);
        chk("dr_rst_data", dma_rdata, 0);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single data memory between two requesters: the CPU MEM stage (port 0) and a DMA/debug master (port 1).
- Grants at most one access per cycle.
- Generates byte enables and merged write data for the CPU's sub-word stores, and extracts and extends CPU loads.
- Stalls the CPU when the DMA master holds the memory.
- Sits between M-stage logic and a byte-enabled DM with combinational read and clocked write.

Parameters:
- MAX_BURST, 4: max consecutive DMA grants while the CPU is requesting.
- WAIT_LIMIT, 8: contested cycles a DMA request may wait before it is forced a grant.
- CNT_W, 4: width of the burst and wait counters; must hold max(MAX_BURST, WAIT_LIMIT).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU store (1) / load (0)
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data, right-aligned
- cpu_op  in  3  0=W, 1=H, 2=HU, 3=B, 4=BU; 5-7 treated as W
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rdata  out  32  extracted/extended load data, valid when cpu_gnt & ~cpu_we
- cpu_err  out  1  misaligned access; no memory effect
- dma_req  in  1  DMA word request
- dma_we  in  1  DMA write
- dma_addr  in  32  DMA byte address; bits [1:0] ignored
- dma_wdata  in  32  DMA write word
- dma_gnt  out  1  DMA access performed this cycle
- dma_rdata  out  32  registered read word
- dma_rvalid  out  1  dma_rdata valid; one cycle after a DMA read grant
- mem_we  out  1  memory write strobe
- mem_addr  out  32  word-aligned address (bits [1:0]=0)
- mem_byteen  out  4  byte enables
- mem_wdata  out  32  lane-positioned write data
- mem_rdata  in  32  memory combinational read data

Behaviour:
- **Reset** (rst==0 at posedge): state=S_CPU, burst_cnt=0, wait_cnt=0, dma_rdata=0, dma_rvalid=0.
- **Combinational outputs:** gnt, stall, err and the mem_* outputs are combinational from current inputs and state. With no grant: mem_we=0, mem_byteen=0, mem_addr=0, mem_wdata=0.
- **Misaligned CPU accesses:**
  - Defined as: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Response: cpu_err=1, cpu_gnt=1, mem_we=0, cpu_rdata=0.
  - Consumes the CPU's slot for arbitration purposes.
- **S_CPU (CPU priority):**
  - cpu_req=1 and (dma_req=0 or wait_cnt<WAIT_LIMIT): grant CPU. If dma_req, wait_cnt++ (saturating).
  - cpu_req=1, dma_req=1, wait_cnt==WAIT_LIMIT: grant DMA, cpu_stall=1, wait_cnt<=0, burst_cnt<=1, go S_DMA.
  - cpu_req=0, dma_req=1: grant DMA, wait_cnt<=0, burst_cnt<=1, go S_DMA.
  - Neither request: idle; wait_cnt<=0.
- **S_DMA (DMA burst):**
  - dma_req=1 and (cpu_req=0 or burst_cnt<MAX_BURST): grant DMA, burst_cnt++ (saturating).
  - dma_req=1, cpu_req=1, burst_cnt==MAX_BURST: grant CPU, burst_cnt<=0, go S_CPU.
  - dma_req=0: burst ends, burst_cnt<=0, go S_CPU. The CPU is granted in this same cycle if cpu_req.
- **CPU store lanes:**
  - W: byteen=1111, wdata=cpu_wdata.
  - H: byteen=0011<<addr[1:0], wdata=cpu_wdata[15:0] replicated ×2.
  - B: byteen=0001<<addr[1:0], wdata=cpu_wdata[7:0] replicated ×4.
  - HU/BU stores behave as H/B.
- **CPU load extraction:**
  - Source is mem_rdata; byte/half selected by addr[1:0].
  - H/B sign-extend; HU/BU zero-extend; W passes through.
- **DMA path:** always word access, byteen=1111. On a read grant, dma_rdata<=mem_rdata and dma_rvalid<=1 at that edge; otherwise dma_rvalid<=0 and dma_rdata holds.
- **Simultaneous events:** exactly one of cpu_gnt and dma_gnt may be 1 in any cycle (assertable invariant).
- **Reset mid-burst:** returns to S_CPU. A pending dma_rvalid is cleared; the read data is lost.
- **Counters:** both saturate at their limit and never wrap.

Test Plan:
1. **Reset and idle.** Hold rst=0 for 2 cycles, then idle. Expect all outputs 0 and state S_CPU. Read back the memory: contents unchanged.
2. **CPU sub-word store and load.**
   - sb addr=0x5, wdata=0x000000AB: expect mem_byteen=0010, mem_wdata=0xABABABAB.
   - lb addr=0x5 with mem_rdata=0x0000AB00: expect cpu_rdata=0xFFFFFFAB.
   - lbu at the same address: expect 0x000000AB.
3. **Misaligned access.** lw addr=0x6: expect cpu_err=1, mem_we=0, no stall. sh addr=0x3: expect cpu_err=1.
4. **DMA burst limit.**
   - cpu_req held at 0, dma_req held at 1 for 6 cycles: expect 6 consecutive dma_gnt.
   - Raise cpu_req at cycle 2: DMA keeps the grant through burst_cnt=4, then cpu_gnt=1; cpu_stall is high in the cycles before that grant.
5. **Starvation guard.** cpu_req and dma_req both constantly 1 from S_CPU: expect 8 cpu_gnt cycles, then dma_gnt on the 9th, then the S_DMA pattern.
6. **DMA read latency.** DMA read addr=0x10 with mem_rdata=0x12345678: expect dma_rvalid=1 and dma_rdata=0x12345678 on the next cycle only. Assert rst=0 in that cycle: dma_rvalid=0.
